custom_rx_seq: RTL

Reconfiguration sequencer for the custom RX front-end DSP chain (IF oscillator, anti-alias filter, mixer, DDC). It decodes user settings-bus writes into shadow registers. On commit it gates baseband output and drains the filter pipeline, then loads the new oscillator phase increment and mode. It mutes output for a programmable settle time before re-enabling baseband strobes, so no sample mixed with a stale or partial configuration reaches the host.

---
 rtl/custom_rx_seq_pkg.sv | 26 ++
 rtl/custom_rx_seq_regs.sv | 44 ++++
 rtl/custom_rx_seq.sv | 115 +++++++++++
 3 files changed

// File: rtl/custom_rx_seq_pkg.sv
// Shared definitions for the custom RX reconfiguration sequencer:
// FSM state encoding, settings-bus register offsets and mode codes.
package custom_rx_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  localparam logic [7:0] OFF_PHASE  = 8'd0;
  localparam logic [7:0] OFF_MODE   = 8'd1;
  localparam logic [7:0] OFF_SETTLE = 8'd2;

  localparam logic [1:0] MODE_PASS   = 2'd0;
  localparam logic [1:0] MODE_MIX    = 2'd1;
  localparam logic [1:0] MODE_BYPASS = 2'd2;

  // The reserved code 3 is folded onto pass-through before it becomes active.
  function automatic logic [1:0] legal_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_PASS : m;
  endfunction

endpackage

// File: rtl/custom_rx_seq_regs.sv
// Settings-bus decode for the RX sequencer: three shadow registers and a
// commit pulse raised combinationally by a write to the mode address.
module custom_rx_seq_regs
  import custom_rx_seq_pkg::*;
#(
  parameter logic [7:0] SR_BASE = 8'd0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  output logic [31:0] shadow_phase,
  output logic [1:0]  shadow_mode,
  output logic [15:0] shadow_settle,
  output logic        commit
);

  localparam logic [7:0] A_PHASE  = SR_BASE + OFF_PHASE;
  localparam logic [7:0] A_MODE   = SR_BASE + OFF_MODE;
  localparam logic [7:0] A_SETTLE = SR_BASE + OFF_SETTLE;

  // A write coinciding with clear is dropped so re-enable reloads the old shadow.
  logic wr;
  assign wr     = set_stb & ~clear;
  assign commit = wr && (set_addr == A_MODE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow_phase  <= '0;
      shadow_mode   <= '0;
      shadow_settle <= '0;
    end else if (wr) begin
      case (set_addr)
        A_PHASE:  shadow_phase  <= set_data;
        A_MODE:   shadow_mode   <= set_data[1:0];
        A_SETTLE: shadow_settle <= set_data[15:0];
        default:  ;
      endcase
    end
  end

endmodule

// File: rtl/custom_rx_seq.sv
// RX reconfiguration sequencer: drain, load, settle, run. The optional gated
// strobe counter is built only when CUSTOM_RX_SEQ_GATE_CNT_EN is defined.
module custom_rx_seq
  import custom_rx_seq_pkg::*;
#(
  parameter logic [7:0]  SR_BASE    = 8'd0,
  parameter int unsigned PIPE_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        enable,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic        ddc_out_strobe,
  output logic [31:0] phase_inc,
  output logic        phase_load,
  output logic [1:0]  mode,
  output logic        ddc_out_enable,
  output logic        bb_gate,
  output logic        busy,
  output logic [15:0] gated_count
);

  localparam logic [15:0] DRAIN_LEN = 16'(PIPE_DEPTH);

  state_t      state, state_next;
  logic        pending;
  logic [15:0] cnt;
  logic [31:0] sh_phase;
  logic [1:0]  sh_mode;
  logic [15:0] sh_settle;
  logic        commit;

  custom_rx_seq_regs #(.SR_BASE(SR_BASE)) u_regs (
    .clock         (clock),
    .reset_n       (reset_n),
    .clear         (clear),
    .set_stb       (set_stb),
    .set_addr      (set_addr),
    .set_data      (set_data),
    .shadow_phase  (sh_phase),
    .shadow_mode   (sh_mode),
    .shadow_settle (sh_settle),
    .commit        (commit)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // RUN looks at the live commit too, so DRAIN starts the cycle after it.
  always_comb begin
    state_next = state;
    if (clear || !enable) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   state_next = ST_LOAD;
        ST_LOAD:   state_next = ST_SETTLE;
        ST_SETTLE: if (cnt <= 16'd1) state_next = ST_RUN;
        ST_RUN:    if (pending || commit) state_next = ST_DRAIN;
        ST_DRAIN:  if (cnt == 16'd1) state_next = ST_LOAD;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    phase_load     = (state == ST_LOAD);
    ddc_out_enable = (state != ST_IDLE);
    bb_gate        = (state == ST_RUN);
    busy           = (state == ST_LOAD) || (state == ST_SETTLE) || (state == ST_DRAIN);
  end

  // Active values are captured on entry to LOAD so they are valid with phase_load.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_inc <= '0;
      mode      <= MODE_PASS;
      cnt       <= '0;
      pending   <= 1'b0;
    end else begin
      if (state_next == ST_LOAD) begin
        phase_inc <= sh_phase;
        mode      <= legal_mode(sh_mode);
        cnt       <= sh_settle;
      end else if (state_next == ST_DRAIN && state != ST_DRAIN) begin
        cnt <= DRAIN_LEN;
      end else if ((state == ST_SETTLE || state == ST_DRAIN) && cnt != '0) begin
        cnt <= cnt - 16'd1;
      end

      if (clear)                        pending <= 1'b0;
      else if (commit)                  pending <= 1'b1;
      else if (state_next == ST_LOAD)   pending <= 1'b0;
    end
  end

`ifdef CUSTOM_RX_SEQ_GATE_CNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                  gated_count <= '0;
    else if (clear)                                gated_count <= '0;
    else if (ddc_out_strobe && busy && gated_count != '1)
      gated_count <= gated_count + 16'd1;
  end
`else
  logic unused_strobe;
  assign unused_strobe = ddc_out_strobe;
  assign gated_count   = '0;
`endif

endmodule
